// File: rtl/seg_scan_driver.sv
// seg_scan_driver: scans four BCD digits onto a common-anode 4-digit 7-segment display, blinking the adjusted pair.
// Optional build macro LEADING_ZERO_BLANK_EN blanks a zero minutes-tens digit outside adjust mode.
module seg_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic [3:0] digit3,
    input  logic [3:0] digit2,
    input  logic [3:0] digit1,
    input  logic [3:0] digit0,
    input  logic       ADJ,
    input  logic       SEL,
    output logic [6:0] dispDigit,
    output logic [3:0] selector
);
    localparam int RW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
    localparam logic [RW-1:0] RMAX = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BMAX = BW'(BLINK_DIV - 1);

    logic [RW-1:0] ref_cnt;
    logic [BW-1:0] blk_cnt;
    logic [1:0]    idx;
    logic          blk_phase;
    logic          tick;
    logic          in_pair;
    logic          lz;
    logic          blank;
    logic [3:0]    cur;
    logic [6:0]    seg;

    assign tick    = ref_cnt == RMAX;
    assign in_pair = SEL ? ~idx[1] : idx[1];
`ifdef LEADING_ZERO_BLANK_EN
    assign lz = digit3 == 4'd0 && !ADJ && idx == 2'd3;
`else
    assign lz = 1'b0;
`endif
    assign blank = (ADJ && blk_phase && in_pair) || lz;

    // Pick the BCD value for the current slot and decode it to active-low segments.
    always_comb begin
        cur = idx == 2'd3 ? digit3 : idx == 2'd2 ? digit2 : idx == 2'd1 ? digit1 : digit0;
        case (cur)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    end

    // Slot timer and digit index; blink timer runs only in adjust mode and restarts visible.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            ref_cnt   <= '0;
            idx       <= 2'd0;
            blk_cnt   <= '0;
            blk_phase <= 1'b0;
        end else begin
            ref_cnt   <= tick ? '0 : ref_cnt + 1'b1;
            idx       <= tick ? idx + 2'd1 : idx;
            blk_cnt   <= !ADJ || blk_cnt == BMAX ? '0 : blk_cnt + 1'b1;
            blk_phase <= !ADJ ? 1'b0 : blk_cnt == BMAX ? ~blk_phase : blk_phase;
        end
    end

    // Registered pin drivers; anode and segments change on the same edge.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            selector  <= 4'b1111;
            dispDigit <= 7'b1111111;
        end else begin
            selector  <= ~(4'b0001 << idx);
            dispDigit <= blank ? 7'b1111111 : seg;
        end
    end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: slot-table and hand-sequence checks of seg_scan_driver with REFRESH_DIV=4, BLINK_DIV=8.
module tb_seg_scan_driver;
    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] BL = 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ = BL;
`else
    localparam logic [6:0] LZ = S0;
`endif

    typedef struct {
        logic [3:0] d3, d2, d1, d0;
        logic       adj, sel;
        logic [3:0] es;
        logic [6:0] eg;
    } vec_t;

    logic       clk = 1'b0;
    logic       RESET;
    logic [3:0] digit3, digit2, digit1, digit0;
    logic       ADJ, SEL;
    logic [6:0] dispDigit;
    logic [3:0] selector;
    int         n_run = 0;
    int         n_fail = 0;
    vec_t       tv[$];

    seg_scan_driver #(.REFRESH_DIV(4), .BLINK_DIV(8)) dut (
        .clk(clk), .RESET(RESET),
        .digit3(digit3), .digit2(digit2), .digit1(digit1), .digit0(digit0),
        .ADJ(ADJ), .SEL(SEL),
        .dispDigit(dispDigit), .selector(selector)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [3:0] es, input logic [6:0] eg);
        n_run++;
        if (selector !== es || dispDigit !== eg) begin
            n_fail++;
            $display("FAIL %s: selector=%b dispDigit=%b, expected selector=%b dispDigit=%b", nm, selector, dispDigit, es, eg);
        end
    endtask

    task automatic add(input logic [3:0] d3, d2, d1, d0, input logic adj, sel,
                       input logic [3:0] es, input logic [6:0] eg);
        vec_t v;
        v = '{d3: d3, d2: d2, d1: d1, d0: d0, adj: adj, sel: sel, es: es, eg: eg};
        tv.push_back(v);
    endtask

    task automatic step(input string nm, input logic [3:0] es, input logic [6:0] eg);
        @(posedge clk);
        @(negedge clk);
        chk(nm, es, eg);
    endtask

    initial begin
        for (int r = 0; r < 2; r++) begin
            add(1, 2, 3, 4, 0, 0, 4'b1110, S4);
            add(1, 2, 3, 4, 0, 0, 4'b1101, S3);
            add(1, 2, 3, 4, 0, 0, 4'b1011, S2);
            add(1, 2, 3, 4, 0, 0, 4'b0111, S1);
        end
        add(1, 2, 3, 4'hA, 0, 0, 4'b1110, BL);
        add(1, 2, 3, 4'hA, 0, 0, 4'b1101, S3);
        add(1, 2, 3, 4'hA, 0, 0, 4'b1011, S2);
        add(1, 2, 3, 4'hA, 0, 0, 4'b0111, S1);
        for (int r = 0; r < 2; r++) begin
            add(1, 2, 3, 4, 1, 0, 4'b1110, S4);
            add(1, 2, 3, 4, 1, 0, 4'b1101, S3);
            add(1, 2, 3, 4, 1, 0, 4'b1011, BL);
            add(1, 2, 3, 4, 1, 0, 4'b0111, BL);
        end
        add(1, 2, 3, 4, 0, 1, 4'b1110, S4);
        add(1, 2, 3, 4, 0, 1, 4'b1101, S3);
        add(1, 2, 3, 4, 1, 1, 4'b1011, S2);
        add(1, 2, 3, 4, 1, 1, 4'b0111, S1);
        add(1, 2, 3, 4, 1, 1, 4'b1110, BL);
        add(1, 2, 3, 4, 1, 1, 4'b1101, BL);
        add(1, 2, 3, 4, 1, 1, 4'b1011, S2);
        add(1, 2, 3, 4, 1, 1, 4'b0111, S1);
        add(1, 2, 3, 4, 1, 1, 4'b1110, BL);
        add(1, 2, 3, 4, 1, 1, 4'b1101, BL);
        add(0, 2, 3, 4, 0, 1, 4'b1011, S2);
        add(0, 2, 3, 4, 0, 1, 4'b0111, LZ);
        add(0, 2, 3, 4, 1, 1, 4'b1110, S4);
        add(0, 2, 3, 4, 1, 1, 4'b1101, S3);
        add(0, 2, 3, 4, 1, 1, 4'b1011, S2);
        add(0, 2, 3, 4, 1, 1, 4'b0111, S0);

        RESET = 1'b0;
        ADJ = 1'b0;
        SEL = 1'b0;
        {digit3, digit2, digit1, digit0} = 16'h1234;
        #1 RESET = 1'b1;
        #1 chk("reset_async", 4'b1111, BL);
        @(negedge clk);
        RESET = 1'b0;
        foreach (tv[s]) begin
            digit3 = tv[s].d3;
            digit2 = tv[s].d2;
            digit1 = tv[s].d1;
            digit0 = tv[s].d0;
            ADJ = tv[s].adj;
            SEL = tv[s].sel;
            for (int c = 0; c < 4; c++) step($sformatf("slot%0d_cyc%0d", s, c), tv[s].es, tv[s].eg);
        end

        {digit3, digit2, digit1, digit0} = 16'h1234;
        ADJ = 1'b0;
        for (int i = 0; i < 20 && selector !== 4'b1011; i++) @(negedge clk);
        n_run++;
        if (selector !== 4'b1011) begin
            n_fail++;
            $display("FAIL sync_slot2: selector=%b, expected 1011 within 20 cycles", selector);
        end
        RESET = 1'b1;
        ADJ = 1'b1;
        SEL = 1'b1;
        #1 chk("reset_midscan", 4'b1111, BL);
        @(negedge clk);
        chk("reset_held", 4'b1111, BL);
        RESET = 1'b0;
        step("restart_slot0_visible", 4'b1110, S4);
        SEL = 1'b0;
        repeat (7) @(posedge clk);
        step("minutes_blank_phase", 4'b1011, BL);
        SEL = 1'b1;
        step("sel_to_seconds", 4'b1011, S2);
        SEL = 1'b0;
        step("sel_back_minutes", 4'b1011, BL);
        ADJ = 1'b0;
        step("adj_fall_unblank", 4'b1011, S2);
        digit3 = 4'd9;
        step("digit_change_midscan", 4'b0111, S9);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
